if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core. Sits directly upstream of the 64-word instruction memory.
- Holds the program counter and drives the memory word address. Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles sequential fetch, branch/jump redirects, stalls, flushes, and a sticky misaligned-target fault.

Parameters:
- ADDR_W, 6: instruction-memory word-address width (2^ADDR_W words).
- RESET_PC, 32'h0000_0000: PC value loaded at reset. Must be word-aligned.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash the IF/ID contents (insert bubble).
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  32  resolved branch target byte address.
- jump  in  1  redirect to the jump target.
- jump_index  in  26  instr_index field of the J-type instruction in decode.
- imem_addr  out  ADDR_W  word address to instruction memory.
- imem_instr  in  32  instruction returned by memory, combinational.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- fault  out  1  sticky misaligned-redirect fault.

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc = RESET_PC.
  - if_id_instr = 32'h0 (NOP).
  - if_id_pc4 = 0.
  - if_id_valid = 0.
  - fault = 0.
  - FSM = RUN.
- imem_addr = pc[ADDR_W+1:2], combinational. pc[1:0] are ignored for addressing.
- Addresses beyond 2^ADDR_W words alias; no fault is raised.
- Fetch latency: the instruction at pc appears on if_id_instr one clock after pc presents it. Memory is read combinationally in the same cycle.
- Jump target = {if_id_pc4[31:28], jump_index, 2'b00}.
- Next-PC priority, evaluated each rising edge in RUN:
  1. jump: pc <= jump target.
  2. branch_taken: pc <= branch_target.
  3. stall: pc holds.
  4. Otherwise pc <= pc + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0.
- A redirect (jump or branch_taken) overrides a simultaneous stall.
- IF/ID update, same edge, in RUN:
  - Redirect or flush: if_id_instr <= 0, if_id_valid <= 0. if_id_pc4 holds.
  - Else stall: all IF/ID fields hold.
  - Else: if_id_instr <= imem_instr, if_id_pc4 <= pc + 4, if_id_valid <= 1.
- flush with stall and no redirect: bubble is inserted, PC holds.
- Misaligned redirect: the selected redirect target has bits [1:0] != 0.
  - FSM goes to FAULT. fault <= 1.
  - pc is not updated. IF/ID is bubbled.
- FSM states:
  - RUN: normal operation.
  - FAULT: pc frozen, IF/ID held as bubble (valid = 0), all inputs ignored, fault = 1.
  - FAULT is left only by reset.
- Reset asserted mid-operation (e.g. during a stall or in FAULT) returns all state to the reset values immediately, without waiting for a clock edge.
- First fetch after reset release: on the first edge, IF/ID loads mem[RESET_PC >> 2] with valid = 1, and pc becomes RESET_PC + 4.

Test Plan:
- Reset then free-run, memory loaded with word k = 32'h1000_0000 + k, RESET_PC = 0 -> imem_addr 0, 1, 2, ...; if_id_instr 32'h1000_0000, 32'h1000_0001, ... one cycle behind; if_id_pc4 = 4, 8, 12, ....
- stall high for 3 cycles at pc = 32'h10 -> pc stays 32'h10; IF/ID holds word 3 with valid = 1; fetch resumes at word 4.
- branch_taken with branch_target = 32'h20 and stall high in the same cycle -> next pc = 32'h20; IF/ID bubble (instr 0, valid 0); next cycle IF/ID = word 8.
- jump and branch_taken together, if_id_pc4 = 32'h8000_0010, jump_index = 26'h5 -> pc = 32'h8000_0014 (jump wins); bubble inserted.
- branch_target = 32'h22 -> fault = 1 next edge; pc frozen; if_id_valid = 0 for 10 further cycles with random inputs; rst_n pulse clears fault and pc = 0.
- pc forced to 32'hFFFF_FFFC via branch -> next pc = 0, imem_addr = 63 then 0; rst_n low mid-stall -> outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and
// registers the fetched word into IF/ID. A misaligned redirect freezes the stage until reset.
module if_stage #(
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic              fault
);

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fault_q, fault_d;

    logic        redirect;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

    assign pc_plus4        = pc_q + 32'd4;
    // Jump region comes from the PC+4 of the J-type instruction now sitting in decode.
    assign jump_target     = {if_id_pc4_q[31:28], jump_index, 2'b00};
    assign redirect        = jump | branch_taken;
    assign redirect_target = jump ? jump_target : branch_target;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;

        unique case (state_q)
            StRun: begin
                if (redirect && (redirect_target[1:0] != 2'b00)) begin
                    state_d       = StFault;
                    fault_d       = 1'b1;
                    if_id_instr_d = 32'h0;
                    if_id_valid_d = 1'b0;
                end else if (redirect) begin
                    pc_d          = redirect_target;
                    if_id_instr_d = 32'h0;
                    if_id_valid_d = 1'b0;
                end else begin
                    if (!stall) begin
                        pc_d = pc_plus4;
                    end
                    if (flush) begin
                        if_id_instr_d = 32'h0;
                        if_id_valid_d = 1'b0;
                    end else if (!stall) begin
                        if_id_instr_d = imem_instr;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                    end
                end
            end
            StFault: begin
                fault_d       = 1'b1;
                if_id_instr_d = 32'h0;
                if_id_valid_d = 1'b0;
            end
            default: begin
                state_d = StFault;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign pc          = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written fault/reset
// sequences, then randomized traffic against a spec-level reference model.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [5:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fault;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;

    if_stage #(
        .ADDR_W  (6),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fault        (fault)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [25:0] ji;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic e_fault);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".imem_addr"}, {26'h0, imem_addr}, {26'h0, e_pc[7:2]});
        chk({tag, ".instr"}, if_id_instr, e_instr);
        chk({tag, ".pc4"}, if_id_pc4, e_pc4);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
        chk({tag, ".fault"}, {31'h0, fault}, {31'h0, e_fault});
    endtask

    task automatic drive(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [25:0] ji);
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_index    = ji;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    // Spec rules applied to the model for one clock edge with the current inputs.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = jump || branch_taken;
        tgt   = jump ? {m_pc4[31:28], jump_index, 2'b00} : branch_target;
        if (m_fault) begin
            m_valid = 1'b0;
        end else if (redir && (tgt % 4 != 0)) begin
            m_fault = 1'b1;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (redir) begin
            m_pc    = tgt;
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (stall) begin
            if (flush) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
        end else begin
            if (flush) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_instr = mem[(m_pc / 4) % 64];
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Asserts reset between edges and checks values before the next edge arrives.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(tag, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;

        vecs[0]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h4,         32'h1000_0000, 32'h4,         1};
        vecs[1]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h8,         32'h1000_0001, 32'h8,         1};
        vecs[2]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'hC,         32'h1000_0002, 32'hC,         1};
        vecs[3]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h10,        32'h1000_0003, 32'h10,        1};
        vecs[4]  = '{1, 0, 0, 32'h0,         0, 26'h0, 32'h10,        32'h1000_0003, 32'h10,        1};
        vecs[5]  = '{1, 0, 0, 32'h0,         0, 26'h0, 32'h10,        32'h1000_0003, 32'h10,        1};
        vecs[6]  = '{1, 0, 0, 32'h0,         0, 26'h0, 32'h10,        32'h1000_0003, 32'h10,        1};
        vecs[7]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h14,        32'h1000_0004, 32'h14,        1};
        vecs[8]  = '{1, 0, 1, 32'h20,        0, 26'h0, 32'h20,        32'h0,         32'h14,        0};
        vecs[9]  = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h24,        32'h1000_0008, 32'h24,        1};
        vecs[10] = '{0, 1, 0, 32'h0,         0, 26'h0, 32'h28,        32'h0,         32'h24,        0};
        vecs[11] = '{1, 1, 0, 32'h0,         0, 26'h0, 32'h28,        32'h0,         32'h24,        0};
        vecs[12] = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h2C,        32'h1000_000A, 32'h2C,        1};
        vecs[13] = '{0, 0, 1, 32'h8000_000C, 0, 26'h0, 32'h8000_000C, 32'h0,         32'h2C,        0};
        vecs[14] = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h8000_0010, 32'h1000_0003, 32'h8000_0010, 1};
        vecs[15] = '{0, 0, 1, 32'h40,        1, 26'h5, 32'h8000_0014, 32'h0,         32'h8000_0010, 0};
        vecs[16] = '{0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0, 32'hFFFF_FFFC, 32'h0,         32'h8000_0010, 0};
        vecs[17] = '{0, 0, 0, 32'h0,         0, 26'h0, 32'h0,         32'h1000_003F, 32'h0,         1};

        drive(0, 0, 0, 32'h0, 0, 26'h0);
        rst_n = 1'b0;
        #12;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].st, vecs[i].fl, vecs[i].br, vecs[i].bt, vecs[i].jp, vecs[i].ji);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                    vecs[i].e_valid, 1'b0);
        end

        // Misaligned branch target: freeze, then ignore everything until reset.
        drive(0, 0, 1, 32'h22, 0, 26'h0);
        tick();
        chk_all("misalign", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), 26'($urandom));
            tick();
            chk_all("frozen", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        async_reset("fault_rst");
        drive(0, 0, 0, 32'h0, 0, 26'h0);
        tick();
        chk_all("post_rst", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 1'b0);

        // Reset arriving in the middle of a stall.
        tick();
        drive(1, 0, 0, 32'h0, 0, 26'h0);
        tick();
        chk_all("stall_pre", 32'h8, 32'h1000_0001, 32'h8, 1'b1, 1'b0);
        #1;
        async_reset("stall_rst");

        // Randomized traffic against the reference model.
        for (int k = 0; k < 64; k++) mem[k] = $urandom;
        @(negedge clk);
        async_reset("rand_rst");
        #1;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            if ($urandom_range(0, 15) != 0) bt[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, bt, $urandom_range(0, 9) == 0, 26'($urandom));
            model_step();
            tick();
            chk_all("rand", m_pc, m_instr, m_pc4, m_valid, m_fault);
            if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
